// File: rtl/rf_writeback_queue_pkg.sv
`default_nettype none
// ============================================================================
// rf_writeback_queue_pkg: shared RF types and writeback-queue constants.
// Rev 1.0
// ============================================================================
package rf_writeback_queue_pkg;

  typedef logic Signal;
  localparam Signal ENABLE  = 1'b1;
  localparam Signal DISABLE = 1'b0;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef logic [REG_ADDR_W-1:0] RegAddr;
  typedef logic [REG_DATA_W-1:0] Register;

  typedef struct packed {
    RegAddr  rd;
    Register data;
  } WbEntry;

  localparam int WB_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/rf_wb_fwd_match.sv
`default_nettype none
// ============================================================================
// rf_wb_fwd_match: youngest pending entry whose rd matches addr (addr 0 never hits).
// Rev 1.0
// ============================================================================
module rf_wb_fwd_match
  import rf_writeback_queue_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] ent_rd   [DEPTH],
  input  logic [DATA_W-1:0] ent_data [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [PTR_W:0]    count,
  input  logic [ADDR_W-1:0] addr,
  output Signal             hit,
  output logic [DATA_W-1:0] fwd
);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    hit   = DISABLE;
    fwd   = '0;
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = head + PTR_W'(k);
      if (((PTR_W+1)'(k) < count) && (addr != '0) && (ent_rd[w_idx] == addr)) begin
        hit = ENABLE;
        fwd = ent_data[w_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_writeback_queue.sv
`default_nettype none
// ============================================================================
// rf_writeback_queue: buffers (rd, data) results, drains one per cycle into the RF, forwards pending values.
// Rev 1.0
// ============================================================================
module rf_writeback_queue
  import rf_writeback_queue_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_rd,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output Signal                    rf_write,
  output logic [ADDR_W-1:0]        rf_rd,
  output logic [DATA_W-1:0]        rf_rd_i,
  input  logic [ADDR_W-1:0]        rs,
  input  logic [ADDR_W-1:0]        rt,
  output Signal                    rs_hit,
  output logic [DATA_W-1:0]        rs_fwd,
  output Signal                    rt_hit,
  output logic [DATA_W-1:0]        rt_fwd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;

  logic w_accept;
  logic w_enq;
  logic w_deq;
  logic w_nonempty;

  // Full is judged on count alone; a same-cycle drain does not open a slot.
  assign in_ready   = (r_count < (PTR_W+1)'(DEPTH));
  assign w_accept   = in_valid && in_ready;
  assign w_enq      = w_accept && (in_rd != '0);
  assign w_nonempty = (r_count != '0);
  assign w_deq      = w_nonempty && drain_en;

  assign rf_write = w_deq ? ENABLE : DISABLE;
  assign rf_rd    = w_nonempty ? r_rd[r_head]   : '0;
  assign rf_rd_i  = w_nonempty ? r_data[r_head] : '0;
  assign count    = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_rd[r_tail]   <= in_rd;
        r_data[r_tail] <= in_data;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_deq) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  rf_wb_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_rs_match (
    .ent_rd   (r_rd),
    .ent_data (r_data),
    .head     (r_head),
    .count    (r_count),
    .addr     (rs),
    .hit      (rs_hit),
    .fwd      (rs_fwd)
  );

  rf_wb_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_rt_match (
    .ent_rd   (r_rd),
    .ent_data (r_data),
    .head     (r_head),
    .count    (r_count),
    .addr     (rt),
    .hit      (rt_hit),
    .fwd      (rt_fwd)
  );

endmodule
`default_nettype wire
